// File: rtl/ray_frame_scheduler_pkg.sv
// Shared constants and types for the ray-march frame scheduler.
// Holds the screen geometry, coordinate widths, the FSM state enum and the per-pixel tag.
package ray_frame_scheduler_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int COORD_X_W     = 10;
  localparam int COORD_Y_W     = 9;
  localparam int INFLIGHT_W    = 7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } sched_state_t;

  typedef struct packed {
    logic sof;
    logic eol;
  } pix_tag_t;

endpackage

// File: rtl/sched_tag_fifo.sv
// Synchronous FIFO of pixel tags that tracks the pipeline's in-flight pixels.
// The head is read combinationally; the raw head is undefined when empty, so the caller gates it.
module sched_tag_fifo
  import ray_frame_scheduler_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  pix_tag_t push_dat,
  input  logic     pop,
  output pix_tag_t head_dat,
  output logic     empty,
  output logic     full
);

  localparam int AW = $clog2(DEPTH);

  pix_tag_t       mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  // The extra pointer bit tells full apart from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/ray_frame_scheduler.sv
// Credit-limited frame coordinate sequencer for the ray-march pipeline, with SOF/EOL head tags.
// Define SCHED_PERF_CNT_EN to add the stall_cycles and frames_done performance counters.
module ray_frame_scheduler
  import ray_frame_scheduler_pkg::*;
#(
  parameter int SCREEN_W     = SCREEN_WIDTH,
  parameter int SCREEN_H     = SCREEN_HEIGHT,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  abort,
  output logic [COORD_X_W-1:0]  coord_x,
  output logic [COORD_Y_W-1:0]  coord_y,
  output logic                  coord_valid,
  input  logic                  pix_accept,
  output logic                  tag_sof,
  output logic                  tag_eol,
  output logic                  busy,
  output logic                  frame_done,
  output logic [INFLIGHT_W-1:0] inflight,
  output logic                  underflow
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [15:0]           frames_done
`endif
);

  localparam logic [COORD_X_W-1:0]  X_LAST   = COORD_X_W'(SCREEN_W - 1);
  localparam logic [COORD_Y_W-1:0]  Y_LAST   = COORD_Y_W'(SCREEN_H - 1);
  localparam logic [INFLIGHT_W-1:0] INFL_MAX = INFLIGHT_W'(MAX_INFLIGHT);

  sched_state_t          state;
  logic [COORD_X_W-1:0]  x;
  logic [COORD_Y_W-1:0]  y;
  logic                  abort_seen;

  logic                  issue;
  logic                  acc_ok;
  logic                  at_eol;
  logic                  at_last;
  pix_tag_t              push_tag;
  pix_tag_t              head_tag;
  logic                  tag_empty;
  logic                  tag_full;

  assign at_eol   = (x == X_LAST);
  assign at_last  = at_eol && (y == Y_LAST);
  // abort blocks issue in the very cycle it is sampled.
  assign issue    = (state == RUN) && !abort && (inflight < INFL_MAX);
  assign acc_ok   = pix_accept && (inflight != '0);
  assign push_tag = '{sof: (x == '0) && (y == '0), eol: at_eol};

  sched_tag_fifo #(
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (issue),
    .push_dat (push_tag),
    .pop      (acc_ok),
    .head_dat (head_tag),
    .empty    (tag_empty),
    .full     (tag_full)
  );

  assign tag_sof = !tag_empty && head_tag.sof;
  assign tag_eol = !tag_empty && head_tag.eol;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      abort_seen  <= 1'b0;
      coord_x     <= '0;
      coord_y     <= '0;
      coord_valid <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      inflight    <= '0;
      underflow   <= 1'b0;
`ifdef SCHED_PERF_CNT_EN
      stall_cycles <= '0;
      frames_done  <= '0;
`endif
    end else begin
      coord_valid <= issue;
      frame_done  <= 1'b0;
      busy        <= (state != IDLE);
      if (issue) begin
        coord_x <= x;
        coord_y <= y;
      end

      case ({issue, acc_ok})
        2'b10:   inflight <= inflight + INFLIGHT_W'(1);
        2'b01:   inflight <= inflight - INFLIGHT_W'(1);
        default: ;
      endcase
      if (pix_accept && (inflight == '0)) underflow <= 1'b1;

`ifdef SCHED_PERF_CNT_EN
      if ((state == RUN) && (inflight == INFL_MAX)) stall_cycles <= stall_cycles + 32'd1;
      if ((state == DRAIN) && (inflight == '0))      frames_done  <= frames_done + 16'd1;
`endif

      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            x          <= '0;
            y          <= '0;
            abort_seen <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            state      <= DRAIN;
            abort_seen <= 1'b1;
          end else if (issue) begin
            if (at_eol) begin
              x <= '0;
              y <= at_last ? '0 : y + COORD_Y_W'(1);
            end else begin
              x <= x + COORD_X_W'(1);
            end
            if (at_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (abort) abort_seen <= 1'b1;
          // Frame ends only once every issued pixel has left the result FIFO.
          if (inflight == '0) begin
            frame_done <= 1'b1;
            x          <= '0;
            y          <= '0;
            abort_seen <= 1'b0;
            state      <= (continuous && !abort_seen && !abort) ? RUN : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  tag_no_overflow: assert property (@(posedge clk) disable iff (rst) !(issue && tag_full));
`endif

endmodule

// File: tb/tb_ray_frame_scheduler.sv
// Scoreboard bench for ray_frame_scheduler with a 4x2 screen and 4 credits.
// Stimulus queues expected issues; a negedge monitor checks coordinates and head tags on accept.
module tb_ray_frame_scheduler;

  localparam int W = 4;
  localparam int H = 2;
  localparam int M = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        abort = 1'b0;
  logic        pix_accept = 1'b0;
  logic [9:0]  coord_x;
  logic [8:0]  coord_y;
  logic        coord_valid;
  logic        tag_sof;
  logic        tag_eol;
  logic        busy;
  logic        frame_done;
  logic [6:0]  inflight;
  logic        underflow;
`ifdef SCHED_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [15:0] frames_done;
`endif

  always #5 clk = ~clk;

  ray_frame_scheduler #(
    .SCREEN_W     (W),
    .SCREEN_H     (H),
    .MAX_INFLIGHT (M)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .continuous   (continuous),
    .abort        (abort),
    .coord_x      (coord_x),
    .coord_y      (coord_y),
    .coord_valid  (coord_valid),
    .pix_accept   (pix_accept),
    .tag_sof      (tag_sof),
    .tag_eol      (tag_eol),
    .busy         (busy),
    .frame_done   (frame_done),
    .inflight     (inflight),
    .underflow    (underflow)
`ifdef SCHED_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .frames_done  (frames_done)
`endif
  );

  typedef struct {
    int x;
    int y;
    bit sof;
    bit eol;
  } exp_t;

  typedef struct {
    bit sof;
    bit eol;
  } tag_t;

  exp_t     exp_q[$];
  tag_t     tag_q[$];
  int       n_tests = 0;
  int       n_fail = 0;
  int       fd_cnt = 0;
  int       n_issue = 0;
  bit       auto_acc = 1'b0;
  logic [2:0] hist = 3'b000;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected pixels in raster order; index i of a frame.
  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.x   = i % W;
      e.y   = (i / W) % H;
      e.sof = (i == 0);
      e.eol = (e.x == W - 1);
      exp_q.push_back(e);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the edge. The packer model
  // accepts each result a fixed number of cycles after it appears when auto_acc is set.
  task automatic cyc();
    @(posedge clk);
    #1;
    hist = {hist[1:0], coord_valid};
    if (auto_acc) pix_accept = hist[2];
  endtask

  task automatic wait_fd(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, int'(seen), 1);
  endtask

  // Monitor: pops expected coordinates on issue, expected tags on accept.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (coord_valid) begin
          n_issue++;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_issue: got (%0d,%0d), expected no issue", coord_x, coord_y);
          end else begin
            exp_t e;
            tag_t t;
            e = exp_q.pop_front();
            chk("coord_x", int'(coord_x), e.x);
            chk("coord_y", int'(coord_y), e.y);
            t.sof = e.sof;
            t.eol = e.eol;
            tag_q.push_back(t);
          end
        end
        if (pix_accept) begin
          if (tag_q.size() > 0) begin
            tag_t t;
            t = tag_q.pop_front();
            chk("head_tag_sof", int'(tag_sof), int'(t.sof));
            chk("head_tag_eol", int'(tag_eol), int'(t.eol));
          end else begin
            chk("empty_tag_sof", int'(tag_sof), 0);
            chk("empty_tag_eol", int'(tag_eol), 0);
          end
        end
        if (frame_done) fd_cnt++;
      end
    end
  end

  initial begin
    int base;
    int fdb;

    // Reset state
    repeat (3) cyc();
    chk("rst_coord_valid", int'(coord_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_inflight", int'(inflight), 0);
    chk("rst_underflow", int'(underflow), 0);
    chk("rst_tag_sof", int'(tag_sof), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    rst = 1'b0;
    cyc();

    // Full-rate frame with the packer accepting every result
    push_n(W * H);
    auto_acc = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    for (int i = 0; i < W * H; i++) begin
      chk("full_rate_valid", int'(coord_valid), 1);
      cyc();
    end
    chk("full_rate_stop", int'(coord_valid), 0);
    wait_fd("full_rate_frame_done");
    chk("busy_at_done", int'(busy), 1);
    cyc();
    chk("busy_after_done", int'(busy), 0);
    chk("full_rate_fd_count", fd_cnt, 1);
    auto_acc = 1'b0;
    pix_accept = 1'b0;
    repeat (2) cyc();

    // Credit stall
    base = n_issue;
    push_n(5);
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    chk("stall_inflight_full", int'(inflight), M);
    repeat (6) cyc();
    chk("stall_no_valid", int'(coord_valid), 0);
    chk("stall_inflight_held", int'(inflight), M);
    chk("stall_issue_count", n_issue - base, M);
`ifdef SCHED_PERF_CNT_EN
    chk("stall_cycles", int'(stall_cycles), 6);
    chk("frames_done_cnt", int'(frames_done), 1);
`endif
    pix_accept = 1'b1;
    cyc();
    pix_accept = 1'b0;
    repeat (3) cyc();
    chk("one_credit_one_issue", n_issue - base, M + 1);
    chk("one_credit_inflight", int'(inflight), M);
    chk("one_credit_queue", exp_q.size(), 0);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    pix_accept = 1'b1;
    repeat (4) cyc();
    pix_accept = 1'b0;
    wait_fd("stall_abort_frame_done");
    cyc();
    chk("stall_abort_idle", int'(busy), 0);

    // Simultaneous issue and accept, then abort after 3 issues and 1 accept
    base = n_issue;
    fdb = fd_cnt;
    push_n(3);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    chk("pre_sim_inflight", int'(inflight), 2);
    chk("pre_sim_head_sof", int'(tag_sof), 1);
    pix_accept = 1'b1;
    cyc();
    pix_accept = 1'b0;
    chk("sim_inflight", int'(inflight), 2);
    chk("sim_head_advanced", int'(tag_sof), 0);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    repeat (3) cyc();
    chk("abort_issue_count", n_issue - base, 3);
    chk("abort_inflight", int'(inflight), 2);
    chk("abort_no_done_yet", fd_cnt, fdb);
    pix_accept = 1'b1;
    cyc();
    pix_accept = 1'b0;
    repeat (3) cyc();
    chk("abort_one_left_no_done", fd_cnt, fdb);
    chk("abort_one_left", int'(inflight), 1);
    pix_accept = 1'b1;
    cyc();
    pix_accept = 1'b0;
    wait_fd("abort_frame_done");
    cyc();
    chk("abort_idle", int'(busy), 0);

    // abort in IDLE is ignored
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    cyc();
    chk("idle_abort_busy", int'(busy), 0);

    // Continuous mode restarts right after frame_done, then rst mid-frame
    push_n(W * H);
    push_n(W * H);
    continuous = 1'b1;
    auto_acc = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_fd("cont_frame_done");
    chk("cont_busy_at_done", int'(busy), 1);
    cyc();
    chk("cont_restart_valid", int'(coord_valid), 1);
    chk("cont_restart_x", int'(coord_x), 0);
    chk("cont_restart_y", int'(coord_y), 0);
    chk("cont_restart_sof", int'(tag_sof), 1);
    repeat (2) cyc();
    rst = 1'b1;
    auto_acc = 1'b0;
    pix_accept = 1'b0;
    continuous = 1'b0;
    hist = 3'b000;
    cyc();
    exp_q.delete();
    tag_q.delete();
    fdb = fd_cnt;
    chk("midrst_coord_valid", int'(coord_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_inflight", int'(inflight), 0);
    chk("midrst_tag_sof", int'(tag_sof), 0);
    chk("midrst_coord_x", int'(coord_x), 0);
    rst = 1'b0;
    repeat (6) cyc();
    chk("midrst_no_frame_done", fd_cnt, fdb);
    chk("midrst_stays_idle", int'(busy), 0);

    // Accept with nothing in flight
    pix_accept = 1'b1;
    cyc();
    pix_accept = 1'b0;
    cyc();
    chk("underflow_set", int'(underflow), 1);
    chk("underflow_inflight", int'(inflight), 0);
    repeat (3) cyc();
    chk("underflow_sticky", int'(underflow), 1);

    chk("leftover_expected", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
